// File: rtl/arbiter4_rr.sv
// ============================================================================
// Module   : arbiter4_rr
// Brief    : 4-way round-robin arbiter with hold limit and forced-release pulse
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbiter4_rr #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic       c_st_idle  = 1'b0;
    localparam logic       c_st_busy  = 1'b1;
    localparam logic [7:0] c_hold_max = 8'(HOLD_MAX);

    logic       r_state;
    logic [1:0] r_ptr;
    logic [7:0] r_hold;

    logic [1:0] w_cand;
    logic [1:0] w_win;
    logic       w_found;
    logic       w_at_max;
    logic       w_drop;
    logic       w_release;

    // First requester found scanning from the rotation pointer upward.
    always_comb begin
        w_cand  = 2'd0;
        w_win   = 2'd0;
        w_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w_cand = r_ptr + 2'(k);
            if (!w_found && req[w_cand]) begin
                w_win   = w_cand;
                w_found = 1'b1;
            end
        end
    end

    assign w_at_max  = (r_hold == c_hold_max);
    assign w_drop    = ~req[gnt_idx];
    assign w_release = done | w_drop | w_at_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_ptr     <= 2'd0;
            r_hold    <= 8'd0;
            gnt       <= 4'd0;
            gnt_idx   <= 2'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_found) begin
                        r_state   <= c_st_busy;
                        gnt       <= 4'b0001 << w_win;
                        gnt_idx   <= w_win;
                        gnt_valid <= 1'b1;
                        r_hold    <= 8'd1;
                    end
                end
                c_st_busy: begin
                    if (w_release) begin
                        r_state   <= c_st_idle;
                        r_ptr     <= gnt_idx + 2'd1;
                        r_hold    <= 8'd0;
                        gnt       <= 4'd0;
                        gnt_idx   <= 2'd0;
                        gnt_valid <= 1'b0;
                        // A limit hit only counts as a timeout when nothing
                        // else would have released the grant anyway.
                        timeout   <= w_at_max & ~done & ~w_drop;
                    end else begin
                        r_hold <= r_hold + 8'd1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
